tx_frame_scheduler: RTL and testbench

Round-robin scheduler that shares one Ethernet frame transmitter FSM among NREQ frame sources (switch ingress queues).
- Picks the next requesting source and drives the framer's enable and length inputs.
- Steers the granted source's byte stream onto the framer data input while the framer is in PREAMBLE..DATA.
- Returns a done/drop pulse to the source.
- Sits between the per-port queues and the framer; the framer's CRC/FCS insertion is untouched.

---
 rtl/tx_frame_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one Ethernet framer among NREQ frame sources.
// Optional per-source frame/drop counters are built when TX_SCHED_STATS_EN is defined.
//
// Ports:
//   iclk, irst_n        clock, synchronous active-low reset
//   ireq[NREQ]          per-source frame-ready request (level)
//   ilen[NREQ*11]       per-source data-field length, source k at [11k+10:11k]
//   idata[NREQ*8]       per-source current byte, source k at [8k+7:8k]
//   ist[3]              framer state (0 IGP .. 7 FCS)
//   oenable, olen       framer launch controls
//   odata_byte          granted source byte steered to the framer
//   ogrant, ord         one-hot grant, per-source byte-advance strobe
//   odone, odrop        one-cycle completion / rejection pulses
//   obusy               scheduler owns the framer
//   isel, ofrm_cnt,     (TX_SCHED_STATS_EN only) counter read select
//   odrop_cnt           and selected source's frame/drop counts
module tx_frame_scheduler #(
  parameter int NREQ           = 4,
  parameter int IGP_CYCLES     = 12,
  parameter int MAX_LEN        = 1500,
  parameter int LAUNCH_TIMEOUT = 64
) (
  input  logic                iclk,
  input  logic                irst_n,
  input  logic [NREQ-1:0]     ireq,
  input  logic [NREQ*11-1:0]  ilen,
  input  logic [NREQ*8-1:0]   idata,
  input  logic [2:0]          ist,
`ifdef TX_SCHED_STATS_EN
  input  logic [2:0]          isel,
  output logic [15:0]         ofrm_cnt,
  output logic [15:0]         odrop_cnt,
`endif
  output logic                oenable,
  output logic [10:0]         olen,
  output logic [7:0]          odata_byte,
  output logic [NREQ-1:0]     ogrant,
  output logic [NREQ-1:0]     ord,
  output logic [NREQ-1:0]     odone,
  output logic [NREQ-1:0]     odrop,
  output logic                obusy
);

  localparam logic [2:0] S_SYNC   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_BUSY   = 3'd4;

  localparam logic [2:0] F_IGP = 3'd0;
  localparam logic [2:0] F_FCS = 3'd7;

  logic [2:0]  state;
  logic [2:0]  ptr;
  logic [2:0]  gidx;
  logic [2:0]  ist_q;
  logic [15:0] wcnt;

  // Sources padded to 8 entries so a 3-bit index is always in range.
  logic [7:0]  req_pad;
  logic [10:0] len_arr [8];
  logic [7:0]  dat_arr [8];

  always_comb begin
    req_pad = '0;
    req_pad[NREQ-1:0] = ireq;
    for (int k = 0; k < 8; k++) begin
      len_arr[k] = '0;
      dat_arr[k] = '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      len_arr[k] = ilen[11*k +: 11];
      dat_arr[k] = idata[8*k +: 8];
    end
  end

  // Scan from the highest offset down so the lowest
  // offset from the pointer wins.
  logic       pick_vld;
  logic [2:0] pick_idx;
  logic [3:0] scan;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    scan     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan = {1'b0, ptr} + 4'(i);
      if (scan >= 4'(NREQ))
        scan = scan - 4'(NREQ);
      if (req_pad[scan[2:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan[2:0];
      end
    end
  end

  logic [2:0] nxt_ptr;
  logic       len_bad;
  logic       feed;

  assign nxt_ptr = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;
  assign len_bad = (olen == 11'd0) || (olen > 11'(MAX_LEN));
  assign feed    = (ist != F_IGP) && (ist != F_FCS);

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state   <= S_SYNC;
      ptr     <= '0;
      gidx    <= '0;
      ist_q   <= F_IGP;
      wcnt    <= '0;
      oenable <= 1'b0;
      olen    <= '0;
      ogrant  <= '0;
      odone   <= '0;
      odrop   <= '0;
    end else begin
      ist_q <= ist;
      odone <= '0;
      odrop <= '0;
      case (state)
        S_SYNC: begin
          if (ist == F_IGP) begin
            if (wcnt == 16'(IGP_CYCLES - 1)) begin
              wcnt  <= '0;
              state <= S_IDLE;
            end else begin
              wcnt <= wcnt + 16'd1;
            end
          end else begin
            wcnt <= '0;
          end
        end
        S_IDLE: begin
          if (pick_vld) begin
            gidx   <= pick_idx;
            ogrant <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            olen   <= len_arr[pick_idx];
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (len_bad) begin
            odrop  <= ogrant;
            ogrant <= '0;
            ptr    <= nxt_ptr;
            state  <= S_IDLE;
          end else begin
            oenable <= 1'b1;
            wcnt    <= '0;
            state   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (ist != F_IGP) begin
            oenable <= 1'b0;
            state   <= S_BUSY;
          end else if (wcnt == 16'(LAUNCH_TIMEOUT - 1)) begin
            // Pointer stays put so the same source retries.
            oenable <= 1'b0;
            odrop   <= ogrant;
            ogrant  <= '0;
            wcnt    <= '0;
            state   <= S_SYNC;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_BUSY: begin
          if (ist == F_IGP && ist_q == F_FCS) begin
            odone  <= ogrant;
            ogrant <= '0;
            ptr    <= nxt_ptr;
            wcnt   <= '0;
            state  <= S_SYNC;
          end
        end
        default: begin
          state <= S_SYNC;
        end
      endcase
    end
  end

  // The framer leaves IGP while still in LAUNCH, so the
  // first preamble cycle already advances the source.
  assign ord = ((state == S_LAUNCH || state == S_BUSY) && feed)
             ? ogrant : '0;

  assign odata_byte = (|ogrant) ? dat_arr[gidx] : 8'h00;

  assign obusy = (state == S_CHECK) || (state == S_LAUNCH) ||
                 (state == S_BUSY);

`ifdef TX_SCHED_STATS_EN
  logic [15:0] frm_cnt [8];
  logic [15:0] drp_cnt [8];

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      for (int k = 0; k < 8; k++) begin
        frm_cnt[k] <= '0;
        drp_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (odone[k] && frm_cnt[k] != 16'hFFFF)
          frm_cnt[k] <= frm_cnt[k] + 16'd1;
        if (odrop[k] && drp_cnt[k] != 16'hFFFF)
          drp_cnt[k] <= drp_cnt[k] + 16'd1;
      end
    end
  end

  assign ofrm_cnt  = frm_cnt[isel];
  assign odrop_cnt = drp_cnt[isel];
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a behavioural framer.
// Table of arbitration vectors plus timeout and mid-frame reset sequences.
module tb_tx_frame_scheduler;

  logic        iclk = 1'b0;
  logic        irst_n;
  logic [3:0]  ireq;
  logic [43:0] ilen;
  logic [31:0] idata;
  logic [2:0]  ist;
  logic        oenable;
  logic [10:0] olen;
  logic [7:0]  odata_byte;
  logic [3:0]  ogrant;
  logic [3:0]  ord;
  logic [3:0]  odone;
  logic [3:0]  odrop;
  logic        obusy;

  always #5 iclk = ~iclk;

  tx_frame_scheduler #(
    .NREQ(4), .IGP_CYCLES(12), .MAX_LEN(1500), .LAUNCH_TIMEOUT(64)
  ) dut (
    .iclk(iclk), .irst_n(irst_n), .ireq(ireq), .ilen(ilen),
    .idata(idata), .ist(ist), .oenable(oenable), .olen(olen),
    .odata_byte(odata_byte), .ogrant(ogrant), .ord(ord),
    .odone(odone), .odrop(odrop), .obusy(obusy)
  );

  // Framer: PRE 7, SFD 1, DA 6, SA 6, LT 2, DATA len, FCS 4.
  logic [2:0]  fr_st  = 3'd0;
  int          fr_cnt = 0;
  logic [10:0] fr_len = 11'd0;
  bit          stuck  = 1'b0;

  assign ist = fr_st;

  function automatic int dur(input logic [2:0] s, input int len);
    case (s)
      3'd1: return 7;
      3'd2: return 1;
      3'd3: return 6;
      3'd4: return 6;
      3'd5: return 2;
      3'd6: return len;
      default: return 4;
    endcase
  endfunction

  always @(posedge iclk) begin
    if (fr_st == 3'd0) begin
      if (oenable && !stuck) begin
        fr_st  <= 3'd1;
        fr_cnt <= 0;
        fr_len <= olen;
      end
    end else if (fr_cnt == dur(fr_st, int'(fr_len)) - 1) begin
      fr_st  <= fr_st + 3'd1;
      fr_cnt <= 0;
    end else begin
      fr_cnt <= fr_cnt + 1;
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [43:0] len;
    int          g;
    bit          drop;
    int          nord;
  } vec_t;

  vec_t       tv [14];
  logic [7:0] dexp [4];
  int         passed = 0;
  int         total  = 0;
  bit         prev_done;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r = -1;
    int c = 0;
    for (int k = 0; k < 4; k++)
      if (v[k]) begin
        if (r < 0) r = k;
        c++;
      end
    if (c > 1) r = -2;
    return r;
  endfunction

  task automatic wait_grant(output int zr, output int g);
    int n = 0;
    zr = 0;
    while (ogrant == 4'd0 && n < 200) begin
      if (ist == 3'd0) zr++;
      else zr = 0;
      @(negedge iclk);
      n++;
    end
    g = idx_of(ogrant);
  endtask

  task automatic run_vec(input vec_t v);
    int          zr, g, n, nord;
    bit          en_seen, lbad, obad;
    logic [43:0] lv;
    logic [10:0] exp_len;
    logic [3:0]  gm;
    ireq    = v.req;
    ilen    = v.len;
    lv      = v.len;
    exp_len = lv[11*v.g +: 11];
    gm      = 4'(1 << v.g);
    wait_grant(zr, g);
    chk("grant_idx", g, v.g);
    if (prev_done) chk("igp_gap", int'(zr >= 12), 1);
    chk("olen", int'(olen), int'(exp_len));
    chk("odata", int'(odata_byte), int'(dexp[v.g]));
    ilen = '1;
    n = 0; nord = 0; en_seen = 0; lbad = 0; obad = 0;
    while (odone == 4'd0 && odrop == 4'd0 && n < 3000) begin
      if (ord[v.g]) nord++;
      if (ord != 4'd0 && ord != gm) obad = 1;
      if (oenable) en_seen = 1;
      if (ogrant != 4'd0 && olen != exp_len) lbad = 1;
      @(negedge iclk);
      n++;
    end
    chk("pulse_seen", int'((odone | odrop) != 4'd0), 1);
    chk("pulse_drop", int'(odrop != 4'd0), int'(v.drop));
    chk("pulse_excl", int'((odone & odrop) != 4'd0), 0);
    chk("pulse_idx", idx_of(odone | odrop), v.g);
    chk("ord_count", nord, v.nord);
    chk("ord_stray", int'(obad), 0);
    chk("enable_seen", int'(en_seen), int'(!v.drop));
    chk("olen_hold", int'(lbad), 0);
    prev_done = !v.drop;
  endtask

  initial begin
    int zr, g, n, en;
    tv[0]  = '{4'b0001, {11'd46, 11'd46, 11'd46, 11'd64}, 0, 1'b0, 86};
    tv[1]  = '{4'b0101, {11'd46, 11'd46, 11'd46, 11'd46}, 2, 1'b0, 68};
    tv[2]  = '{4'b0101, {11'd46, 11'd46, 11'd46, 11'd46}, 0, 1'b0, 68};
    tv[3]  = '{4'b0110, {11'd46, 11'd46, 11'd0, 11'd46}, 1, 1'b1, 0};
    tv[4]  = '{4'b0110, {11'd46, 11'd46, 11'd0, 11'd46}, 2, 1'b0, 68};
    tv[5]  = '{4'b0010, {11'd46, 11'd46, 11'd1501, 11'd46}, 1, 1'b1, 0};
    tv[6]  = '{4'b1000, {11'd46, 11'd46, 11'd46, 11'd46}, 3, 1'b0, 68};
    tv[7]  = '{4'b1111, {11'd46, 11'd46, 11'd46, 11'd46}, 0, 1'b0, 68};
    tv[8]  = '{4'b1111, {11'd46, 11'd46, 11'd46, 11'd46}, 1, 1'b0, 68};
    tv[9]  = '{4'b1111, {11'd46, 11'd46, 11'd46, 11'd46}, 2, 1'b0, 68};
    tv[10] = '{4'b1111, {11'd46, 11'd46, 11'd46, 11'd46}, 3, 1'b0, 68};
    tv[11] = '{4'b1111, {11'd46, 11'd46, 11'd46, 11'd46}, 0, 1'b0, 68};
    tv[12] = '{4'b0010, {11'd46, 11'd46, 11'd1500, 11'd46}, 1, 1'b0, 1522};
    tv[13] = '{4'b0100, {11'd46, 11'd1, 11'd46, 11'd46}, 2, 1'b0, 23};
    dexp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    irst_n = 1'b0;
    ireq   = '0;
    ilen   = '0;
    idata  = 32'hD3C2B1A0;
    repeat (3) @(negedge iclk);
    chk("rst_grant", int'(ogrant), 0);
    chk("rst_enable", int'(oenable), 0);
    chk("rst_olen", int'(olen), 0);
    chk("rst_data", int'(odata_byte), 0);
    chk("rst_ord", int'(ord), 0);
    chk("rst_pulses", int'(odone | odrop), 0);
    chk("rst_busy", int'(obusy), 0);
    irst_n    = 1'b1;
    prev_done = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(tv[i]);

    // Framer stuck in IGP: launch times out, same source retried.
    stuck = 1'b1;
    ireq  = 4'b0001;
    ilen  = {4{11'd46}};
    wait_grant(zr, g);
    chk("to_grant", g, 0);
    n = 0; en = 0;
    while (odrop == 4'd0 && n < 300) begin
      if (oenable) en++;
      @(negedge iclk);
      n++;
    end
    chk("to_enable_cycles", en, 64);
    chk("to_drop", int'(odrop), 1);
    chk("to_no_done", int'(odone), 0);
    wait_grant(zr, g);
    chk("to_regrant", g, 0);
    chk("to_igp", int'(zr >= 12), 1);
    stuck = 1'b0;
    n = 0;
    while (odone == 4'd0 && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk("to_done", int'(odone), 1);

    // One-cycle reset while the framer is in DATA.
    ilen = {11'd46, 11'd46, 11'd46, 11'd64};
    wait_grant(zr, g);
    chk("mr_grant", g, 0);
    n = 0;
    while (ist != 3'd6 && n < 200) begin
      @(negedge iclk);
      n++;
    end
    chk("mr_in_data", int'(ist), 6);
    irst_n = 1'b0;
    @(negedge iclk);
    irst_n = 1'b1;
    chk("mr_grant_clr", int'(ogrant), 0);
    chk("mr_enable", int'(oenable), 0);
    chk("mr_olen", int'(olen), 0);
    chk("mr_data", int'(odata_byte), 0);
    chk("mr_ord", int'(ord), 0);
    chk("mr_busy", int'(obusy), 0);
    wait_grant(zr, g);
    chk("mr_regrant", g, 0);
    chk("mr_igp", int'(zr >= 12), 1);
    n = 0;
    while (odone == 4'd0 && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk("mr_done", int'(odone), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
